prng_sched: RTL and testbench

PRNG_SCHED -- requirements
Module: prng_sched

---
 rtl/prng_pkg.sv | 28 ++
 rtl/rr_arb.sv | 34 +++
 rtl/prng_sched.sv | 157 +++++++++++++++
 tb/tb_prng_sched.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prng_pkg.sv
// Shared constants and types for the PRNG request scheduler.
//   PRNG_M / PRNG_A : Lehmer core modulus and multiplier driven to the core.
//   DEFAULT_SEED    : per-requester seed loaded on reset or on a degenerate result.
//   state_t         : scheduler FSM states.
package prng_pkg;

    localparam logic [31:0] PRNG_M = 32'd2147483647;  // 2^31 - 1
    localparam logic [31:0] PRNG_A = 32'd16807;

    localparam int unsigned SEED_TABLE_N = 4;
    localparam logic [31:0] DEFAULT_SEED [SEED_TABLE_N] = '{32'd5, 32'd7, 32'd9, 32'd11};

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDeliver
    } state_t;

    // Requesters beyond the table continue the odd sequence 5, 7, 9, 11, 13, ...
    function automatic logic [31:0] default_seed(input int unsigned idx);
        if (idx < SEED_TABLE_N) begin
            return DEFAULT_SEED[idx];
        end
        return 32'(2 * idx + 5);
    endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter.
//   req   : request vector
//   ptr   : index of the requester holding highest priority this cycle
//   gnt   : one-hot grant (all zero when nothing is requested)
//   valid : at least one request present
module rr_arb #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic            valid
);

    always_comb begin
        int unsigned idx;
        logic        found;
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        // Scan starting at ptr and wrapping; first requester hit wins.
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/prng_sched.sv
// Scheduler sharing one Lehmer PRNG core among NREQ requesters.
//   clk, rst                  : clock, asynchronous active-high reset
//   req / ack                 : per-requester level request, one-cycle ack pulse
//   rand_out                  : delivered number, valid with ack, held between acks
//   err                       : one-cycle pulse when the core watchdog aborts a job
//   seed_wr/seed_id/seed_data : direct seed register write (0 selects the default)
//   prng_start/m/a/seed       : start pulse and operands to the core
//   prng_done/prng_rand       : core completion and result
module prng_sched
    import prng_pkg::*;
#(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned WD_MAX = 255
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NREQ-1:0]                req,
    output logic [NREQ-1:0]                ack,
    output logic [31:0]                    rand_out,
    output logic                           err,
    input  logic                           seed_wr,
    input  logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] seed_id,
    input  logic [31:0]                    seed_data,
    output logic                           prng_start,
    output logic [31:0]                    prng_m,
    output logic [31:0]                    prng_a,
    output logic [31:0]                    prng_seed,
    input  logic                           prng_done,
    input  logic [31:0]                    prng_rand
);

    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned WDW = $clog2(WD_MAX + 1);

    state_t            state_q;
    logic [IDW-1:0]    id_q;
    logic [IDW-1:0]    ptr_q;
    logic [WDW-1:0]    wd_q;
    logic [31:0]       cap_q;
    logic [31:0]       rand_q;
    logic [NREQ-1:0]   ack_q;
    logic              err_q;
    logic              start_q;
    logic [31:0]       seed_q [NREQ];

    logic [NREQ-1:0]   gnt;
    logic              gnt_valid;
    logic [IDW-1:0]    gnt_id;
    logic [IDW-1:0]    id_next;
    logic              cap_ok;

    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] id);
        if (int'(id) == NREQ - 1) begin
            return '0;
        end
        return id + 1'b1;
    endfunction

    // A requester still shows req in its ack cycle; mask it so it is not re-granted.
    rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arb (
        .req   (req & ~ack_q),
        .ptr   (ptr_q),
        .gnt   (gnt),
        .valid (gnt_valid)
    );

    always_comb begin
        gnt_id = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                gnt_id = IDW'(i);
            end
        end
    end

    assign id_next = wrap_inc(id_q);
    assign cap_ok  = (cap_q != 32'd0) && (cap_q < PRNG_M);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            id_q    <= '0;
            ptr_q   <= '0;
            wd_q    <= '0;
            cap_q   <= '0;
            rand_q  <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
        end else begin
            ack_q   <= '0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (gnt_valid && !prng_done) begin
                        id_q    <= gnt_id;
                        start_q <= 1'b1;  // high exactly during StIssue
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    wd_q    <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    if (prng_done) begin
                        cap_q   <= prng_rand;
                        state_q <= StDeliver;
                    end else if (wd_q == WDW'(WD_MAX - 1)) begin
                        err_q   <= 1'b1;
                        ptr_q   <= id_next;
                        state_q <= StIdle;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                StDeliver: begin
                    ack_q   <= NREQ'(1) << id_q;
                    rand_q  <= cap_q;
                    ptr_q   <= id_next;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Seed file: an external write takes precedence over the delivery update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                seed_q[i] <= default_seed(i);
            end
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (seed_wr && (seed_id == IDW'(i))) begin
                    seed_q[i] <= (seed_data == 32'd0) ? default_seed(i) : seed_data;
                end else if ((state_q == StDeliver) && (id_q == IDW'(i))) begin
                    seed_q[i] <= cap_ok ? cap_q : default_seed(i);
                end
            end
        end
    end

    assign ack        = ack_q;
    assign err        = err_q;
    assign rand_out   = rand_q;
    assign prng_start = start_q;
    assign prng_m     = PRNG_M;
    assign prng_a     = PRNG_A;
    assign prng_seed  = seed_q[id_q];

endmodule

// File: tb/tb_prng_sched.sv
// Directed bench for prng_sched with a behavioural Lehmer core and an ack scoreboard.
module tb_prng_sched;

    localparam int unsigned NREQ     = 4;
    localparam int unsigned WD_MAX   = 255;
    localparam int          CORE_LAT = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] ack;
    logic [31:0]     rand_out;
    logic            err;
    logic            seed_wr;
    logic [1:0]      seed_id;
    logic [31:0]     seed_data;
    logic            prng_start;
    logic [31:0]     prng_m;
    logic [31:0]     prng_a;
    logic [31:0]     prng_seed;
    logic            prng_done;
    logic [31:0]     prng_rand;

    prng_sched #(
        .NREQ   (NREQ),
        .WD_MAX (WD_MAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .ack        (ack),
        .rand_out   (rand_out),
        .err        (err),
        .seed_wr    (seed_wr),
        .seed_id    (seed_id),
        .seed_data  (seed_data),
        .prng_start (prng_start),
        .prng_m     (prng_m),
        .prng_a     (prng_a),
        .prng_seed  (prng_seed),
        .prng_done  (prng_done),
        .prng_rand  (prng_rand)
    );

    always #5 clk = ~clk;

    // Behavioural core: seed * a mod m after CORE_LAT idle cycles; can be made unresponsive.
    logic        core_dead;
    logic        core_busy;
    int          core_cnt;
    logic [31:0] core_acc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            core_busy <= 1'b0;
            core_cnt  <= 0;
            core_acc  <= '0;
            prng_done <= 1'b0;
            prng_rand <= '0;
        end else begin
            prng_done <= 1'b0;
            if (prng_start) begin
                if (!core_dead) begin
                    core_busy <= 1'b1;
                    core_cnt  <= CORE_LAT;
                    core_acc  <= 32'((64'(prng_seed) * 64'(prng_a)) % 64'(prng_m));
                end
            end else if (core_busy) begin
                if (core_cnt == 0) begin
                    prng_done <= 1'b1;
                    prng_rand <= core_acc;
                    core_busy <= 1'b0;
                end else begin
                    core_cnt <= core_cnt - 1;
                end
            end
        end
    end

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   checks     = 0;
    int   errors     = 0;
    int   err_seen   = 0;
    int   start_seen = 0;
    int   cyc        = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst) begin
            if (err === 1'b1) err_seen++;
            if (prng_start === 1'b1) start_seen++;
            if (ack !== '0) begin
                if (sb_q.size() == 0) begin
                    check("ack_unexpected", 64'(ack), 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("ack_onehot", 64'(ack), 64'(4'b0001 << e.id));
                    check("rand_out", 64'(rand_out), 64'(e.val));
                end
            end
        end
    end

    task automatic do_reset(input string tag);
        rst     = 1'b1;
        req     = '0;
        seed_wr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check({tag, "_ack"}, 64'(ack), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
        check({tag, "_start"}, 64'(prng_start), 64'd0);
        check({tag, "_rand_out"}, 64'(rand_out), 64'd0);
        rst = 1'b0;
    endtask

    task automatic seed_write(input logic [1:0] id, input logic [31:0] data);
        seed_wr   = 1'b1;
        seed_id   = id;
        seed_data = data;
        @(negedge clk);
        #1;
        seed_wr = 1'b0;
    endtask

    // Raise req[id], wait for its ack, check latency, start count and hold of rand_out.
    task automatic request(input int id, input logic [31:0] val, input string tag);
        int done_cyc;
        int start0;
        bit got;
        sb_q.push_back(exp_t'{id: 2'(id), val: val});
        start0   = start_seen;
        done_cyc = -1;
        got      = 1'b0;
        req[id]  = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            #1;
            if (prng_done && done_cyc < 0) done_cyc = cyc;
            if (ack[id]) begin
                got = 1'b1;
                break;
            end
        end
        req[id] = 1'b0;
        check({tag, "_ack_seen"}, 64'(got), 64'd1);
        check({tag, "_latency"}, 64'(cyc - done_cyc), 64'd2);
        check({tag, "_start_pulses"}, 64'(start_seen - start0), 64'd1);
        repeat (3) @(negedge clk);
        #1;
        check({tag, "_hold"}, 64'(rand_out), 64'(val));
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int got;
        int e0;
        int c0;
        int d;
        rst       = 1'b1;
        req       = '0;
        seed_wr   = 1'b0;
        seed_id   = '0;
        seed_data = '0;
        core_dead = 1'b0;

        // Reset state and constant operands.
        do_reset("rst0");
        check("prng_m", 64'(prng_m), 64'd2147483647);
        check("prng_a", 64'(prng_a), 64'd16807);

        // Single requester, two chained draws.
        request(0, 32'd84035, "r0_first");
        request(0, 32'd1412376245, "r0_second");

        // All four requesting: round-robin order 0,1,2,3 then back to 0.
        do_reset("rst1");
        sb_q.push_back(exp_t'{id: 2'd0, val: 32'd84035});
        sb_q.push_back(exp_t'{id: 2'd1, val: 32'd117649});
        sb_q.push_back(exp_t'{id: 2'd2, val: 32'd151263});
        sb_q.push_back(exp_t'{id: 2'd3, val: 32'd184877});
        sb_q.push_back(exp_t'{id: 2'd0, val: 32'd1412376245});
        got = 0;
        req = 4'hF;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            #1;
            if (ack != '0) begin
                got++;
                if (got == 5) begin
                    req = '0;
                    break;
                end
            end
        end
        req = '0;
        check("rr_ack_count", 64'(got), 64'd5);
        repeat (20) @(negedge clk);
        #1;
        check("rr_sb_drained", 64'(sb_q.size()), 64'd0);

        // Dead core: watchdog abort, no ack, seed untouched.
        do_reset("rst2");
        core_dead = 1'b1;
        e0 = err_seen;
        c0 = cyc;
        req[0] = 1'b1;
        for (int k = 0; k < WD_MAX + 50; k++) begin
            @(negedge clk);
            #1;
            if (err) break;
        end
        req = '0;
        d = cyc - c0;
        check("wd_err_count", 64'(err_seen - e0), 64'd1);
        check("wd_delay_in_range", 64'((d >= WD_MAX) && (d <= WD_MAX + 4)), 64'd1);
        @(negedge clk);
        #1;
        check("wd_err_one_cycle", 64'(err), 64'd0);
        core_dead = 1'b0;
        request(0, 32'd84035, "wd_retry");

        // Seed writes: zero selects default, otherwise value used directly.
        do_reset("rst3");
        seed_write(2'd2, 32'd0);
        request(2, 32'd151263, "seed_zero");
        seed_write(2'd2, 32'd1);
        request(2, 32'd16807, "seed_one");

        // Seed write colliding with the delivery update: the write wins.
        do_reset("rst4");
        sb_q.push_back(exp_t'{id: 2'd1, val: 32'd117649});
        req[1] = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            #1;
            if (prng_done) break;
        end
        @(negedge clk);
        #1;
        seed_write(2'd1, 32'd3);
        req[1] = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("collide_sb_drained", 64'(sb_q.size()), 64'd0);
        request(1, 32'd50421, "collide_next");

        // Reset in the middle of a computation.
        do_reset("rst5");
        req[0] = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            #1;
            if (prng_start) break;
        end
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_ack", 64'(ack), 64'd0);
        check("midrst_err", 64'(err), 64'd0);
        check("midrst_start", 64'(prng_start), 64'd0);
        req = '0;
        @(negedge clk);
        #1;
        rst = 1'b0;
        request(0, 32'd84035, "post_rst");

        repeat (10) @(negedge clk);
        #1;
        check("final_sb_empty", 64'(sb_q.size()), 64'd0);
        check("final_err_total", 64'(err_seen), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
